// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RISC-V pipeline: tracks EX/MEM destination
// tags, picks operand forwarding sources, inserts load-use stalls, holds the
// pipe for multi-cycle multiplies and flushes IF/ID on taken branches.
module hazard_ctrl #(
  parameter int MUL_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [4:0] id_rs1_addr,
  input  logic [4:0] id_rs2_addr,
  input  logic       id_rs1_used,
  input  logic       id_rs2_used,
  input  logic [4:0] id_rd_addr,
  input  logic       id_writeback_en,
  input  logic       id_is_load,
  input  logic       id_is_mul,
  input  logic       ex_branch_taken,
  output logic       stall_fetch,
  output logic       hold_id_ex,
  output logic       bubble_id_ex,
  output logic       flush_if_id,
  output logic [1:0] rs1_fwd_sel,
  output logic [1:0] rs2_fwd_sel,
  output logic       ex_busy
);

  typedef enum logic {RUN = 1'b0, MULWAIT = 1'b1} state_t;

  localparam logic [3:0] LP_MUL_LOAD = 4'(MUL_CYCLES - 1);

  state_t     r_state;
  logic [3:0] r_mul_cnt;

  logic       r_ex_vld;
  logic [4:0] r_ex_rd;
  logic       r_ex_wb;
  logic       r_ex_load;

  logic       r_mem_vld;
  logic [4:0] r_mem_rd;
  logic       r_mem_wb;

  logic w_busy;
  logic w_ex_m1, w_ex_m2, w_mem_m1, w_mem_m2;
  logic w_load_use;
  logic w_flush;
  logic w_issue;

  // x0 never matches: a zero rd can never produce a forwarded value or a stall.
  function automatic logic tag_match(input logic vld, input logic wb,
                                     input logic [4:0] rd, input logic [4:0] src,
                                     input logic used);
    return vld & wb & (rd != 5'd0) & (rd == src) & used;
  endfunction

  // EX wins over MEM; an EX load or a multiply still in progress has no result yet.
  function automatic logic [1:0] fwd_sel(input logic ex_m, input logic ex_ok,
                                         input logic mem_m);
    if (ex_m && ex_ok) return 2'b01;
    else if (mem_m)    return 2'b10;
    else               return 2'b00;
  endfunction

  // Hazard detection from the ID operands against the tracked tags.
  always_comb begin
    w_busy     = (r_state == MULWAIT);
    w_ex_m1    = tag_match(r_ex_vld, r_ex_wb, r_ex_rd, id_rs1_addr, id_rs1_used);
    w_ex_m2    = tag_match(r_ex_vld, r_ex_wb, r_ex_rd, id_rs2_addr, id_rs2_used);
    w_mem_m1   = tag_match(r_mem_vld, r_mem_wb, r_mem_rd, id_rs1_addr, id_rs1_used);
    w_mem_m2   = tag_match(r_mem_vld, r_mem_wb, r_mem_rd, id_rs2_addr, id_rs2_used);
    w_load_use = id_valid & r_ex_load & (w_ex_m1 | w_ex_m2);
    // EX holds a multiply while busy, so a branch indication there is meaningless.
    w_flush    = ex_branch_taken & ~w_busy;
    w_issue    = id_valid & ~w_load_use & ~w_flush & ~w_busy;
  end

  // Pipeline control outputs; all forced low while reset is asserted.
  always_comb begin
    stall_fetch  = 1'b0;
    hold_id_ex   = 1'b0;
    bubble_id_ex = 1'b0;
    flush_if_id  = 1'b0;
    rs1_fwd_sel  = 2'b00;
    rs2_fwd_sel  = 2'b00;
    ex_busy      = 1'b0;
    if (!rst) begin
      stall_fetch  = w_busy | (w_load_use & ~w_flush);
      hold_id_ex   = w_busy;
      bubble_id_ex = ~w_busy & (w_flush | w_load_use);
      flush_if_id  = w_flush;
      rs1_fwd_sel  = fwd_sel(w_ex_m1, ~r_ex_load & ~w_busy, w_mem_m1);
      rs2_fwd_sel  = fwd_sel(w_ex_m2, ~r_ex_load & ~w_busy, w_mem_m2);
      ex_busy      = w_busy;
    end
  end

  // Tag pipeline and multiply-occupancy FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= RUN;
      r_mul_cnt <= 4'd0;
      r_ex_vld  <= 1'b0;
      r_ex_rd   <= 5'd0;
      r_ex_wb   <= 1'b0;
      r_ex_load <= 1'b0;
      r_mem_vld <= 1'b0;
      r_mem_rd  <= 5'd0;
      r_mem_wb  <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          r_mem_vld <= r_ex_vld;
          r_mem_rd  <= r_ex_rd;
          r_mem_wb  <= r_ex_wb;
          r_ex_vld  <= w_issue;
          r_ex_rd   <= w_issue ? id_rd_addr : 5'd0;
          r_ex_wb   <= w_issue & id_writeback_en;
          r_ex_load <= w_issue & id_is_load;
          if (w_issue && id_is_mul && (MUL_CYCLES > 1)) begin
            r_mul_cnt <= LP_MUL_LOAD;
            r_state   <= MULWAIT;
          end
        end
        MULWAIT: begin
          // EX keeps the multiply; nothing leaves EX, so MEM sees a bubble.
          r_mem_vld <= 1'b0;
          r_mem_rd  <= 5'd0;
          r_mem_wb  <= 1'b0;
          r_mul_cnt <= r_mul_cnt - 4'd1;
          if (r_mul_cnt <= 4'd1) r_state <= RUN;
        end
        default: r_state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: stimulus pushes expected outputs per cycle,
// a negedge monitor pops and compares.
module tb_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs1_addr;
  logic [4:0] id_rs2_addr;
  logic       id_rs1_used;
  logic       id_rs2_used;
  logic [4:0] id_rd_addr;
  logic       id_writeback_en;
  logic       id_is_load;
  logic       id_is_mul;
  logic       ex_branch_taken;
  logic       stall_fetch;
  logic       hold_id_ex;
  logic       bubble_id_ex;
  logic       flush_if_id;
  logic [1:0] rs1_fwd_sel;
  logic [1:0] rs2_fwd_sel;
  logic       ex_busy;

  typedef struct {
    string      name;
    logic [8:0] outs;  // {stall, hold, bubble, flush, rs1[1:0], rs2[1:0], busy}
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  hazard_ctrl #(.MUL_CYCLES(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_valid        (id_valid),
    .id_rs1_addr     (id_rs1_addr),
    .id_rs2_addr     (id_rs2_addr),
    .id_rs1_used     (id_rs1_used),
    .id_rs2_used     (id_rs2_used),
    .id_rd_addr      (id_rd_addr),
    .id_writeback_en (id_writeback_en),
    .id_is_load      (id_is_load),
    .id_is_mul       (id_is_mul),
    .ex_branch_taken (ex_branch_taken),
    .stall_fetch     (stall_fetch),
    .hold_id_ex      (hold_id_ex),
    .bubble_id_ex    (bubble_id_ex),
    .flush_if_id     (flush_if_id),
    .rs1_fwd_sel     (rs1_fwd_sel),
    .rs2_fwd_sel     (rs2_fwd_sel),
    .ex_busy         (ex_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: combinational outputs are valid every cycle; compare mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t       e;
      logic [8:0] got;
      e   = q.pop_front();
      got = {stall_fetch, hold_id_ex, bubble_id_ex, flush_if_id,
             rs1_fwd_sel, rs2_fwd_sel, ex_busy};
      tests++;
      if (got !== e.outs) begin
        fails++;
        $display("FAIL %s: got stall/hold/bub/flush/s1/s2/busy=%b required %b",
                 e.name, got, e.outs);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic wb,
                        input logic ld, input logic mul, input logic br);
    id_valid        = v;
    id_rs1_addr     = rs1;
    id_rs1_used     = u1;
    id_rs2_addr     = rs2;
    id_rs2_used     = u2;
    id_rd_addr      = rd;
    id_writeback_en = wb;
    id_is_load      = ld;
    id_is_mul       = mul;
    ex_branch_taken = br;
  endtask

  task automatic expect_o(input string nm, input logic sf, input logic h,
                          input logic b, input logic f, input logic [1:0] s1,
                          input logic [1:0] s2, input logic busy);
    exp_t e;
    e.name = nm;
    e.outs = {sf, h, b, f, s1, s2, busy};
    q.push_back(e);
  endtask

  initial begin
    rst = 1'b1;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset forces everything low even with a branch request present.
    tick(); set_id(1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 0, 1);
    expect_o("reset_state", 0, 0, 0, 0, 2'b00, 2'b00, 0);
    tick(); rst = 1'b0;

    // 1: add x1,x2,x3 then add x2,x1,x3 -> EX forward on rs1
    set_id(1, 5'd2, 1, 5'd3, 1, 5'd1, 1, 0, 0, 0);
    expect_o("t1_add_x1", 0, 0, 0, 0, 2'b00, 2'b00, 0);
    tick(); set_id(1, 5'd1, 1, 5'd3, 1, 5'd2, 1, 0, 0, 0);
    expect_o("t1_ex_fwd", 0, 0, 0, 0, 2'b01, 2'b00, 0);

    // 2: add x1; nop; sub x4,x1,x1 -> MEM forward on both
    tick(); set_id(1, 5'd0, 1, 5'd0, 1, 5'd1, 1, 0, 0, 0);
    expect_o("t2_add_x1", 0, 0, 0, 0, 2'b00, 2'b00, 0);
    tick(); set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_o("t2_nop", 0, 0, 0, 0, 2'b00, 2'b00, 0);
    tick(); set_id(1, 5'd1, 1, 5'd1, 1, 5'd4, 1, 0, 0, 0);
    expect_o("t2_mem_fwd", 0, 0, 0, 0, 2'b10, 2'b10, 0);

    // 3: lw x5 then add x6,x5,x0 -> one stall, then MEM forward
    tick(); set_id(1, 5'd0, 1, 5'd0, 0, 5'd5, 1, 1, 0, 0);
    expect_o("t3_lw", 0, 0, 0, 0, 2'b00, 2'b00, 0);
    tick(); set_id(1, 5'd5, 1, 5'd0, 1, 5'd6, 1, 0, 0, 0);
    expect_o("t3_load_use", 1, 0, 1, 0, 2'b00, 2'b00, 0);
    tick();
    expect_o("t3_after_stall", 0, 0, 0, 0, 2'b10, 2'b00, 0);

    // 4: mul x7 then add x8,x7 -> 3 busy cycles (branch ignored), then EX forward
    tick(); set_id(1, 5'd0, 1, 5'd0, 1, 5'd7, 1, 0, 1, 0);
    expect_o("t4_mul", 0, 0, 0, 0, 2'b00, 2'b00, 0);
    tick(); set_id(1, 5'd7, 1, 5'd0, 0, 5'd8, 1, 0, 0, 1);
    expect_o("t4_busy1_br", 1, 1, 0, 0, 2'b00, 2'b00, 1);
    tick(); ex_branch_taken = 1'b0;
    expect_o("t4_busy2", 1, 1, 0, 0, 2'b00, 2'b00, 1);
    tick();
    expect_o("t4_busy3", 1, 1, 0, 0, 2'b00, 2'b00, 1);
    tick();
    expect_o("t4_done_fwd", 0, 0, 0, 0, 2'b01, 2'b00, 0);

    // 5: lw x5 in EX, dependent in ID, branch taken -> flush wins
    tick(); set_id(1, 5'd0, 1, 5'd0, 0, 5'd5, 1, 1, 0, 0);
    expect_o("t5_lw", 0, 0, 0, 0, 2'b00, 2'b00, 0);
    tick(); set_id(1, 5'd5, 1, 5'd5, 1, 5'd6, 1, 0, 0, 1);
    expect_o("t5_flush", 0, 0, 1, 1, 2'b00, 2'b00, 0);
    tick(); ex_branch_taken = 1'b0;
    expect_o("t5_ex_invalid", 0, 0, 0, 0, 2'b10, 2'b10, 0);

    // 6a: lw x0 then reader of x0 -> no forwarding, no stall
    tick(); set_id(1, 5'd0, 0, 5'd0, 0, 5'd0, 1, 1, 0, 0);
    expect_o("t6_lw_x0", 0, 0, 0, 0, 2'b00, 2'b00, 0);
    tick(); set_id(1, 5'd0, 1, 5'd0, 1, 5'd10, 1, 0, 0, 0);
    expect_o("t6_read_x0", 0, 0, 0, 0, 2'b00, 2'b00, 0);

    // 6b: reset during the second MULWAIT cycle
    tick(); set_id(1, 5'd0, 1, 5'd0, 1, 5'd11, 1, 0, 1, 0);
    expect_o("t6_mul", 0, 0, 0, 0, 2'b00, 2'b00, 0);
    tick(); set_id(1, 5'd11, 1, 5'd0, 0, 5'd12, 1, 0, 0, 0);
    expect_o("t6_busy1", 1, 1, 0, 0, 2'b00, 2'b00, 1);
    tick(); rst = 1'b1;
    expect_o("t6_rst_mid_mul", 0, 0, 0, 0, 2'b00, 2'b00, 0);
    tick(); rst = 1'b0;
    expect_o("t6_after_rst", 0, 0, 0, 0, 2'b00, 2'b00, 0);
    // The instruction now issues from RUN; a fresh multiply must give 3 busy cycles.
    tick(); set_id(1, 5'd12, 1, 5'd0, 0, 5'd13, 1, 0, 1, 0);
    expect_o("t6_ex_fwd_post_rst", 0, 0, 0, 0, 2'b01, 2'b00, 0);
    tick(); set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_o("t6_mul2_busy1", 1, 1, 0, 0, 2'b00, 2'b00, 1);
    tick();
    expect_o("t6_mul2_busy2", 1, 1, 0, 0, 2'b00, 2'b00, 1);
    tick();
    expect_o("t6_mul2_busy3", 1, 1, 0, 0, 2'b00, 2'b00, 1);
    tick();
    expect_o("t6_mul2_done", 0, 0, 0, 0, 2'b00, 2'b00, 0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard controller for the 5-stage RISC-V core. It tracks the destination tags of instructions in EX and MEM and derives the forwarding selects the ID/EX register latches as its ALU loopback controls. It generates load-use stalls, holds the pipe while a multi-cycle multiply occupies EX, and flushes on taken branches. It sits beside the decoder and drives the IF/ID and ID/EX register enables.

Parameters:
MUL_CYCLES, 4, total EX occupancy of a multiply instruction (1..15); 1 means single-cycle.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
id_valid  in  1  ID holds a real instruction
id_rs1_addr  in  5  ID source register 1
id_rs2_addr  in  5  ID source register 2
id_rs1_used  in  1  instruction reads rs1
id_rs2_used  in  1  instruction reads rs2
id_rd_addr  in  5  ID destination register
id_writeback_en  in  1  instruction writes rd
id_is_load  in  1  instruction is a load
id_is_mul  in  1  instruction is a multi-cycle multiply
ex_branch_taken  in  1  branch in EX resolved taken this cycle
stall_fetch  out  1  hold PC and IF/ID
hold_id_ex  out  1  ID/EX keeps its contents
bubble_id_ex  out  1  ID/EX loads its NOP
flush_if_id  out  1  IF/ID loads NOP
rs1_fwd_sel  out  2  00 regfile, 01 EX result (loopback), 10 MEM result
rs2_fwd_sel  out  2  same encoding for rs2
ex_busy  out  1  multiply still occupying EX

Behaviour:
- Interface: one clock (clk). Reset (rst) is asynchronous and active-high.
- Internal state:
  - EX tag: valid, rd, wb, load.
  - MEM tag: valid, rd, wb.
  - 4-bit mul counter.
  - FSM with states RUN and MULWAIT.
- Reset: all tags invalid, counter 0, state RUN. While rst is high, every output is forced to 0.
- Outputs are combinational from the ID inputs and registered state. There is no output latency.
- Match rule: a tag matches a source register when all of the following hold: tag valid, wb=1, rd!=0, rd==src, and src is used. Register x0 never forwards and never stalls.
- Forwarding, per source register:
  - EX tag matches and is not a load: select 01.
  - Otherwise, MEM tag matches: select 10.
  - Otherwise: select 00.
  - EX takes priority over MEM.
- Load-use: EX tag is a load and matches either source, with id_valid=1. Response: stall_fetch=1, bubble_id_ex=1. The next cycle sees the load in MEM, so the select becomes 10.
- Flush: ex_branch_taken=1 gives flush_if_id=1 and bubble_id_ex=1, with stall_fetch=0. Flush overrides load-use.
- Issue condition: id_valid, no stall, no flush, not MULWAIT.
- Tag pipeline (advances each cycle unless in MULWAIT):
  - EX tag takes the issuing ID instruction if it issues; otherwise it becomes a bubble.
  - MEM tag takes the EX tag.
- Multiply issue: when a multiply issues and MUL_CYCLES>1, the counter loads MUL_CYCLES-1 and the FSM enters MULWAIT.
- MULWAIT:
  - Outputs: ex_busy=1, stall_fetch=1, hold_id_ex=1, bubble_id_ex=0.
  - EX tag is frozen; MEM tag receives a bubble.
  - Counter decrements each cycle. When it reaches 1, the next state is RUN.
  - Forwarding from EX is suppressed while busy: a result not yet ready returns 00 unless MEM matches.
- ex_branch_taken is ignored in MULWAIT, because EX holds a multiply.
- Reset mid-MULWAIT: returns immediately to RUN with the counter at 0 and all outputs at 0.

Test Plan:
1. add x1 issued, then add x2,x1,x3 in ID next cycle -> rs1_fwd_sel=01, rs2_fwd_sel=00, no stall.
2. add x1; nop; sub x4,x1,x1 -> on sub's ID cycle, rs1_fwd_sel=rs2_fwd_sel=10.
3. lw x5 then add x6,x5,x0 -> one cycle with stall_fetch=1 and bubble_id_ex=1; next cycle rs1_fwd_sel=10, stall 0.
4. MUL_CYCLES=4: mul x7 then add x8,x7 -> ex_busy, stall_fetch and hold_id_ex high for exactly 3 cycles; then rs1_fwd_sel=01 for one cycle.
5. lw x5 in EX with a dependent instruction in ID, plus ex_branch_taken=1 in the same cycle -> flush_if_id=1, bubble_id_ex=1, stall_fetch=0. Next cycle: EX tag invalid, no stall.
6. rd=x0 writer followed by a reader of x0 -> selects 00, no stall. Separately, assert rst during MULWAIT cycle 2 -> all outputs 0 immediately; after release, state RUN and ex_busy=0.
